// File: rtl/io_device_fifo_bank_if.sv
// io_device_fifo_bank_if
//   Bundles the CPU-side and external-side signals of io_device_fifo_bank.
//   master: CPU + external harness driving strobes, observing read data/flags.
//   slave : the FIFO bank itself.
//   CPU side : device_id, value_in, is_write, is_read -> value_out
//   Ext side : ext_id, ext_value_in, ext_push, ext_pop -> ext_value_out, ext_valid
//   Status   : error (sticky protocol-violation flag)
interface io_device_fifo_bank_if #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ID_WIDTH = 8
);
   logic [ID_WIDTH-1:0] device_id;
   logic [WIDTH-1:0]    value_in;
   logic                is_write;
   logic                is_read;
   logic [WIDTH-1:0]    value_out;
   logic [ID_WIDTH-1:0] ext_id;
   logic [WIDTH-1:0]    ext_value_in;
   logic                ext_push;
   logic                ext_pop;
   logic [WIDTH-1:0]    ext_value_out;
   logic                ext_valid;
   logic                error;

   modport master (
      output device_id, value_in, is_write, is_read,
      output ext_id, ext_value_in, ext_push, ext_pop,
      input  value_out, ext_value_out, ext_valid, error
   );

   modport slave (
      input  device_id, value_in, is_write, is_read,
      input  ext_id, ext_value_in, ext_push, ext_pop,
      output value_out, ext_value_out, ext_valid, error
   );
endinterface

// File: rtl/io_device_fifo_bank.sv
// io_device_fifo_bank
//   NUM_DEVICES IO devices, each backed by a DEPTH-entry FIFO. Output devices
//   (OUT_MASK bit set) are filled by the CPU and drained externally; input
//   devices are filled externally and drained by the CPU. STATUS_ID reads back
//   per-device empty/full flags. Any protocol violation sets a sticky error.
//   Ports:
//     clk    : clock, all state changes on posedge
//     resetn : synchronous active-low reset
//     bus    : slave side of io_device_fifo_bank_if (CPU + external signals)
module io_device_fifo_bank #(
   parameter int unsigned                 WIDTH       = 32,
   parameter int unsigned                 ID_WIDTH    = 8,
   parameter int unsigned                 NUM_DEVICES = 4,
   parameter int unsigned                 DEPTH       = 4,
   parameter logic [NUM_DEVICES-1:0]      OUT_MASK    = 4'b1010,
   parameter logic [ID_WIDTH-1:0]         STATUS_ID   = 8'hFF
) (
   input logic                    clk,
   input logic                    resetn,
   io_device_fifo_bank_if.slave   bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [ID_WIDTH-1:0] NUM_ID = ID_WIDTH'(NUM_DEVICES);

   logic [WIDTH-1:0] mem_q    [NUM_DEVICES][DEPTH];
   logic [PW-1:0]    rd_ptr_q [NUM_DEVICES];
   logic [PW-1:0]    wr_ptr_q [NUM_DEVICES];
   logic [CW-1:0]    count_q  [NUM_DEVICES];
   logic [WIDTH-1:0] shadow_q [NUM_DEVICES];
   logic             error_q;
   logic             error_d;

   logic [NUM_DEVICES-1:0] push_req, pop_req, push_ok, pop_ok, empty, full;

   // Request decode and violation detection. For a given device, push and pop
   // each come from exactly one side, fixed by its direction in OUT_MASK.
   always_comb begin
      logic viol;
      logic cpu_hit, ext_hit, cpu_wr, cpu_rd;
      push_req = '0;
      pop_req  = '0;
      push_ok  = '0;
      pop_ok   = '0;
      empty    = '0;
      full     = '0;
      cpu_wr   = bus.is_write && !bus.is_read;
      cpu_rd   = bus.is_read && !bus.is_write;
      viol     = bus.is_write && bus.is_read;
      if ((bus.is_write || bus.is_read) && (bus.device_id >= NUM_ID)) viol = 1'b1;
      if ((bus.ext_push || bus.ext_pop) && (bus.ext_id >= NUM_ID)) viol = 1'b1;
      for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
         cpu_hit  = (bus.device_id == ID_WIDTH'(d));
         ext_hit  = (bus.ext_id == ID_WIDTH'(d));
         empty[d] = (count_q[d] == '0);
         full[d]  = (count_q[d] == CW'(DEPTH));
         if (OUT_MASK[d]) begin
            push_req[d] = cpu_hit && cpu_wr;
            pop_req[d]  = ext_hit && bus.ext_pop;
            if ((cpu_hit && cpu_rd) || (ext_hit && bus.ext_push)) viol = 1'b1;
         end else begin
            push_req[d] = ext_hit && bus.ext_push;
            pop_req[d]  = cpu_hit && cpu_rd;
            if ((cpu_hit && cpu_wr) || (ext_hit && bus.ext_pop)) viol = 1'b1;
         end
         // A same-cycle valid pop frees the slot, so a push to a full FIFO proceeds.
         pop_ok[d]  = pop_req[d] && !empty[d];
         push_ok[d] = push_req[d] && (!full[d] || pop_ok[d]);
         if (pop_req[d] && !pop_ok[d]) viol = 1'b1;
         if (push_req[d] && !push_ok[d]) viol = 1'b1;
      end
      error_d = error_q | viol;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         error_q <= 1'b0;
         for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
            rd_ptr_q[d] <= '0;
            wr_ptr_q[d] <= '0;
            count_q[d]  <= '0;
            shadow_q[d] <= '0;
         end
      end else begin
         error_q <= error_d;
         for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
            if (push_ok[d]) wr_ptr_q[d] <= wr_ptr_q[d] + 1'b1;
            if (pop_ok[d])  rd_ptr_q[d] <= rd_ptr_q[d] + 1'b1;
            count_q[d] <= count_q[d] + CW'(push_ok[d]) - CW'(pop_ok[d]);
            if (push_ok[d] && OUT_MASK[d]) shadow_q[d] <= bus.value_in;
         end
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
         if (resetn && push_ok[d])
            mem_q[d][wr_ptr_q[d]] <= OUT_MASK[d] ? bus.value_in : bus.ext_value_in;
      end
   end

   always_comb begin
      bus.value_out     = '0;
      bus.ext_value_out = '0;
      bus.ext_valid     = 1'b0;
      for (int unsigned d = 0; d < NUM_DEVICES; d++) begin
         if (bus.device_id == ID_WIDTH'(d)) begin
            if (OUT_MASK[d])    bus.value_out = shadow_q[d];
            else if (!empty[d]) bus.value_out = mem_q[d][rd_ptr_q[d]];
         end
         if (bus.device_id == STATUS_ID) begin
            bus.value_out[2*d]   = !empty[d];
            bus.value_out[2*d+1] = full[d];
         end
         if ((bus.ext_id == ID_WIDTH'(d)) && OUT_MASK[d] && !empty[d]) begin
            bus.ext_valid     = 1'b1;
            bus.ext_value_out = mem_q[d][rd_ptr_q[d]];
         end
      end
   end

   assign bus.error = error_q;
endmodule

// File: tb/tb_io_device_fifo_bank.sv
// tb_io_device_fifo_bank
//   Directed self-checking bench for io_device_fifo_bank (default parameters:
//   dev1/dev3 outputs, dev0/dev2 inputs, DEPTH 4, STATUS_ID 8'hFF).
module tb_io_device_fifo_bank;
   logic clk = 1'b0;
   logic resetn;
   int   checks = 0;
   int   failures = 0;

   io_device_fifo_bank_if #(.WIDTH(32), .ID_WIDTH(8)) bus ();

   io_device_fifo_bank #(
      .WIDTH(32), .ID_WIDTH(8), .NUM_DEVICES(4), .DEPTH(4),
      .OUT_MASK(4'b1010), .STATUS_ID(8'hFF)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.is_write     = 1'b0;
      bus.is_read      = 1'b0;
      bus.ext_push     = 1'b0;
      bus.ext_pop      = 1'b0;
      bus.value_in     = '0;
      bus.ext_value_in = '0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic read_id(input logic [7:0] id, output logic [31:0] v);
      bus.device_id = id;
      #1;
      v = bus.value_out;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      idle();
      bus.device_id = 8'h00;
      bus.ext_id    = 8'h01;
      do_reset();
      read_id(8'h00, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_value_out got %h exp %h", v, 32'h0); end
      checks++; if (bus.ext_valid !== 1'b0) begin failures++; $display("FAIL reset_ext_valid got %b exp 0", bus.ext_valid); end
      checks++; if (bus.ext_value_out !== 32'h0) begin failures++; $display("FAIL reset_ext_value got %h exp 0", bus.ext_value_out); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL reset_error got %b exp 0", bus.error); end
      read_id(8'hFF, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_status got %h exp 0", v); end
   endtask

   task automatic test_output_device();
      logic [31:0] v;
      bus.device_id = 8'h01;
      bus.value_in  = 32'hE5F84AB1;
      bus.is_write  = 1'b1;
      step();
      bus.is_write  = 1'b0;
      read_id(8'h01, v);
      checks++; if (v !== 32'hE5F84AB1) begin failures++; $display("FAIL out_shadow got %h exp E5F84AB1", v); end
      bus.ext_id = 8'h01;
      #1;
      checks++; if (bus.ext_valid !== 1'b1) begin failures++; $display("FAIL out_ext_valid got %b exp 1", bus.ext_valid); end
      checks++; if (bus.ext_value_out !== 32'hE5F84AB1) begin failures++; $display("FAIL out_ext_value got %h exp E5F84AB1", bus.ext_value_out); end
      bus.ext_pop = 1'b1;
      step();
      bus.ext_pop = 1'b0;
      #1;
      checks++; if (bus.ext_valid !== 1'b0) begin failures++; $display("FAIL out_after_pop_valid got %b exp 0", bus.ext_valid); end
      read_id(8'h01, v);
      checks++; if (v !== 32'hE5F84AB1) begin failures++; $display("FAIL out_shadow_kept got %h exp E5F84AB1", v); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL out_error got %b exp 0", bus.error); end
   endtask

   task automatic fill_dev0();
      bus.ext_id = 8'h00;
      for (int i = 1; i <= 4; i++) begin
         bus.ext_value_in = 32'(i);
         bus.ext_push = 1'b1;
         step();
      end
      bus.ext_push = 1'b0;
   endtask

   task automatic test_fill_input();
      logic [31:0] v;
      do_reset();
      fill_dev0();
      read_id(8'hFF, v);
      checks++; if (v !== 32'h3) begin failures++; $display("FAIL fill_status got %h exp 3", v); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL fill_error_before got %b exp 0", bus.error); end
      bus.ext_value_in = 32'h5;
      bus.ext_push = 1'b1;
      step();
      bus.ext_push = 1'b0;
      checks++; if (bus.error !== 1'b1) begin failures++; $display("FAIL overflow_error got %b exp 1", bus.error); end
      for (int i = 1; i <= 4; i++) begin
         read_id(8'h00, v);
         checks++; if (v !== 32'(i)) begin failures++; $display("FAIL pop_order_%0d got %h exp %h", i, v, 32'(i)); end
         bus.is_read = 1'b1;
         step();
         bus.is_read = 1'b0;
      end
      read_id(8'h00, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL drained_value got %h exp 0", v); end
      read_id(8'hFF, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL drained_status got %h exp 0", v); end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] v;
      logic [31:0] exp_seq [4];
      exp_seq = '{32'h2, 32'h3, 32'h4, 32'h9};
      do_reset();
      fill_dev0();
      bus.device_id    = 8'h00;
      bus.is_read      = 1'b1;
      bus.ext_value_in = 32'h9;
      bus.ext_push     = 1'b1;
      step();
      idle();
      read_id(8'hFF, v);
      checks++; if (v !== 32'h3) begin failures++; $display("FAIL pushpop_status got %h exp 3", v); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL pushpop_error got %b exp 0", bus.error); end
      for (int i = 0; i < 4; i++) begin
         read_id(8'h00, v);
         checks++; if (v !== exp_seq[i]) begin failures++; $display("FAIL pushpop_seq_%0d got %h exp %h", i, v, exp_seq[i]); end
         bus.is_read = 1'b1;
         step();
         bus.is_read = 1'b0;
      end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL pushpop_drain_error got %b exp 0", bus.error); end
   endtask

   task automatic test_errors();
      logic [31:0] v;
      for (int k = 0; k < 6; k++) begin
         do_reset();
         bus.value_in     = 32'hDEADBEEF;
         bus.ext_value_in = 32'h12345678;
         case (k)
            0: begin bus.device_id = 8'h00; bus.is_read = 1'b1; end
            1: begin bus.device_id = 8'h00; bus.is_write = 1'b1; end
            2: begin bus.device_id = 8'hFF; bus.is_write = 1'b1; end
            3: begin bus.device_id = 8'h01; bus.is_write = 1'b1; bus.is_read = 1'b1; end
            4: begin bus.ext_id = 8'h01; bus.ext_push = 1'b1; end
            default: begin bus.ext_id = 8'h07; bus.ext_push = 1'b1; end
         endcase
         step();
         idle();
         checks++; if (bus.error !== 1'b1) begin failures++; $display("FAIL err_case_%0d got %b exp 1", k, bus.error); end
         read_id(8'hFF, v);
         checks++; if (v !== 32'h0) begin failures++; $display("FAIL err_status_%0d got %h exp 0", k, v); end
         read_id(8'h01, v);
         checks++; if (v !== 32'h0) begin failures++; $display("FAIL err_shadow_%0d got %h exp 0", k, v); end
      end
      do_reset();
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL err_cleared got %b exp 0", bus.error); end
   endtask

   task automatic test_back_to_back_reset();
      logic [31:0] v;
      do_reset();
      // CPU writes dev1 while the external side pushes dev0 in the same cycle.
      bus.device_id    = 8'h01;
      bus.value_in     = 32'hAA;
      bus.is_write     = 1'b1;
      bus.ext_id       = 8'h00;
      bus.ext_value_in = 32'hBB;
      bus.ext_push     = 1'b1;
      step();
      idle();
      read_id(8'hFF, v);
      checks++; if (v !== 32'h5) begin failures++; $display("FAIL b2b_status got %h exp 5", v); end
      read_id(8'h00, v);
      checks++; if (v !== 32'hBB) begin failures++; $display("FAIL b2b_dev0 got %h exp BB", v); end
      read_id(8'h01, v);
      checks++; if (v !== 32'hAA) begin failures++; $display("FAIL b2b_dev1 got %h exp AA", v); end
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL b2b_error got %b exp 0", bus.error); end
      // Reset with a conflicting strobe pending must win.
      resetn        = 1'b0;
      bus.device_id = 8'h01;
      bus.is_write  = 1'b1;
      bus.is_read   = 1'b1;
      step();
      idle();
      resetn = 1'b1;
      checks++; if (bus.error !== 1'b0) begin failures++; $display("FAIL rst_error got %b exp 0", bus.error); end
      read_id(8'hFF, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_status got %h exp 0", v); end
      read_id(8'h01, v);
      checks++; if (v !== 32'h0) begin failures++; $display("FAIL rst_shadow got %h exp 0", v); end
      bus.ext_id = 8'h01;
      #1;
      checks++; if (bus.ext_valid !== 1'b0) begin failures++; $display("FAIL rst_ext_valid got %b exp 0", bus.ext_valid); end
   endtask

   initial begin
      resetn        = 1'b0;
      bus.device_id = '0;
      bus.ext_id    = '0;
      idle();
      test_reset();
      test_output_device();
      test_fill_input();
      test_full_push_pop();
      test_errors();
      test_back_to_back_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end
endmodule
